// File: rtl/x_stream_tx.sv
// x_stream_tx: holds one LENX-word vector in a local single-port memory and streams it, address 0 first.
// Latency: start edge t -> first valid at t+2; start-to-done 2*LENX+1 cycles (LENX+2 with XTX_SKID_EN).
// Backpressure: m_ready_x low freezes m_valid_x/m_data_out_x; valid is registered, never combinational on ready.
//
// Optional feature macro: XTX_SKID_EN -- when defined, the next word is read on every handshake so the
// stream runs at one word per cycle; when undefined, each word is re-fetched after its handshake
// (one word per two cycles).
//
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   wr_en/wr_addr/wr_data  load port, honoured only while idle and for wr_addr < LENX
//   start              level, sampled while idle; begins a transmission
//   busy, done         transmission in progress; one-cycle pulse after the final handshake
//   m_data_out_x, m_valid_x, m_ready_x   valid/ready output stream
module x_stream_tx #(
    parameter int WIDTH = 16,
    parameter int LENX  = 8,
    parameter int ADDRX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [ADDRX-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [ADDRX:0]   LEN_C  = (ADDRX+1)'(LENX);
    localparam logic [ADDRX-1:0] LAST_C = ADDRX'(LENX - 1);

    state_t           state_q, state_d;
    logic [ADDRX-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             prime_q, prime_d;
    logic [WIDTH-1:0] rd_q;

    logic [WIDTH-1:0] mem_q [LENX];

    logic             rd_en;
    logic [ADDRX-1:0] rd_addr;
    logic             wr_ok;
    logic             hs;
    logic             last;

    assign hs    = vld_q & m_ready_x;
    assign last  = (cnt_q == LAST_C);
    // Writes are only taken while idle, so the single memory port never sees a read and a write together.
    assign wr_ok = (state_q == IDLE) && wr_en && ({1'b0, wr_addr} < LEN_C);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prime_d = prime_q;
        rd_en   = 1'b0;
        rd_addr = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    prime_d = 1'b1;
                end
            end

            FETCH: begin
                rd_en = 1'b1;
                // The first fetch after start spends an extra cycle: address 0 is registered at t+1
                // and presented at t+2, giving the same start-to-first-valid latency in both builds.
                if (prime_q) begin
                    prime_d = 1'b0;
                end else begin
                    state_d = SEND;
                    vld_d   = 1'b1;
                end
            end

            SEND: begin
                if (hs) begin
                    if (last) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDRX'(1);
`ifdef XTX_SKID_EN
                        // Read the following word on the handshake edge; rd_q then holds it
                        // from that edge on and is left untouched through any stall.
                        rd_en   = 1'b1;
                        rd_addr = cnt_q + ADDRX'(1);
`else
                        state_d = FETCH;
                        vld_d   = 1'b0;
`endif
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prime_q <= prime_d;
        end
    end

    // Read/prefetch register; it drives the stream data directly and only changes on a read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem_q[rd_addr];
        end
    end

    // Vector storage is deliberately not reset so a loaded vector survives reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign m_valid_x    = vld_q;
    assign m_data_out_x = rd_q;

endmodule

// File: doc/x_stream_tx.md
# x_stream_tx

Stream transmitter for the x input of the generated convolution layers. It holds one LENX-word input vector in a local single-port memory, loaded by a simple write port. On a start pulse it transmits the vector, address 0 first, over the valid/ready stream that the layer's s_data_in_x/s_valid_x/s_ready_x port accepts. It is used as the x-side driver in layer-level benches and as the glue between a host loader and a layer.

## Interface

- WIDTH, 16, word width in bits (signed data, passed through unmodified)
- LENX, 8, words per vector (must be ≥ 2)
- ADDRX, 3, address width; ≥ ceil(log2(LENX))

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- wr_en  in  1  load-port write strobe
- wr_addr  in  ADDRX  load-port word address
- wr_data  in  WIDTH  load-port word
- start  in  1  begin transmitting the stored vector (level, sampled per cycle)
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse after the last word's handshake
- m_data_out_x  out  WIDTH  stream data
- m_valid_x  out  1  stream valid
- m_ready_x  in  1  stream ready from the consumer

## Operation

- State machine with states IDLE, FETCH and SEND. The state resets to IDLE.
- Reset values: busy=0, done=0, m_valid_x=0, m_data_out_x=0, and the word counter is 0. The memory array is not reset, so its contents survive reset.
- IDLE:
  - A write with wr_en=1 and wr_addr<LENX stores wr_data. A write with wr_addr≥LENX is ignored.
  - start=1 moves the machine to FETCH, sets busy=1 and clears the counter.
  - If wr_en and start are high in the same cycle, the write is committed first. The written word is the one transmitted.
- FETCH:
  - Issues a memory read at the counter address.
  - Moves to SEND on the next edge.
- SEND:
  - m_valid_x=1 and m_data_out_x holds the word.
  - A handshake is m_valid_x && m_ready_x at a rising edge.
  - On a handshake the counter increments.
  - On the handshake of word LENX-1, the machine returns to IDLE, sets busy=0 and pulses done=1.
- Handshake rules:
  - While m_valid_x=1 and m_ready_x=0, m_data_out_x and m_valid_x stay stable.
  - m_valid_x never depends combinationally on m_ready_x.
- While busy=1:
  - wr_en is ignored.
  - start is ignored.
- Reset asserted mid-transmission:
  - Takes effect at the next edge and returns the block to IDLE with outputs at their reset values.
  - Any partially sent vector is abandoned, and done is not pulsed.
- Counter wrap: the counter never exceeds LENX-1. After the final word the counter clears; it does not wrap mid-vector.

## Timing

- start sampled at edge t:
  - Edge t: the machine enters FETCH and busy=1 from t.
  - Edge t+1: the address-0 read is registered.
  - Edge t+2: m_valid_x=1 with word 0.
- The last handshake at edge t gives done=1, busy=0 and m_valid_x=0 for the cycle after t. done clears at t+1.
- A new start is accepted at the earliest in the cycle in which done=1.
- Throughput depends on XTX_SKID_EN (see Configuration).
- Minimum vector time from the start edge to the done edge:
  - Without the macro: 2·LENX + 1 cycles with m_ready_x held at 1.
  - With the macro: LENX + 2 cycles.

## Configuration

- XTX_SKID_EN:
  - Defined:
    - The read address is driven to counter+1 combinationally whenever a handshake occurs.
    - A prefetch register holds the next word.
    - After a handshake at edge t that is not the last, m_valid_x stays 1 and m_data_out_x shows the next word from t.
    - Sustained rate is one word per cycle.
    - A stall (m_ready_x=0) must not drop or duplicate a word.
  - Not defined:
    - After a non-final handshake at edge t, m_valid_x=0 for one cycle (the machine re-enters FETCH).
    - m_valid_x=1 with the next word from t+1.
    - Sustained rate is one word per two cycles.
- Word order, data values, done/busy behaviour and reset behaviour are identical in both builds.

## Test plan

- Basic vector: load 1,2,3,4,5,6,7,8 (LENX=8), pulse start, hold m_ready_x=1.
  - Required: words 1…8 in order, first m_valid_x at start edge+2.
  - Required: done is a single pulse; 17 cycles from the start edge to the done edge without the macro, 10 with it.
- Backpressure: toggle m_ready_x 1,0,0,1,… randomly.
  - Required: each of the 8 words is delivered exactly once, in order.
  - Required: data and valid are stable across every stall cycle.
- Negative and extreme values: load -32768, 32767, -1, 0, …
  - Required: bit-exact pass-through on m_data_out_x.
- Ignored inputs while busy: pulse start and wr_en (wr_addr=0, wr_data=99) mid-transmission.
  - Required: the transmission is unaffected.
  - Required: a second start afterwards sends the original word 0, not 99.
- Same-cycle write and start: in IDLE, wr_en=1, wr_addr=0, wr_data=-5 together with start=1.
  - Required: the first transmitted word is -5.
- Reset mid-vector: assert reset (0) after 3 handshakes.
  - Required: next cycle m_valid_x=0, busy=0, and no done pulse.
  - Required: a subsequent start resends the full stored vector from word 0.
